lfs_evt_reader: RTL
===================

LFS_EVT_READER -- requirements
Module: lfs_evt_reader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, counter register window base; offsets 0x20/0x24/0x28/0x2C are added to it.
REQ-002 Parameter POLL_GAP, default 16, idle cycles between status polls that return "empty".
REQ-003 Parameter POP_GAP, default 8, idle cycles after a pop read before the next status read (minimum 4).
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for ack.
REQ-005 clk_i  in  1  single clock.
REQ-006 rstn_i  in  1  reset; asynchronous, active-low.
REQ-007 enable_i  in  1  1 = drain the counter FIFO.
REQ-008 m_addr_o  out  32  bus address.
REQ-009 m_wdata_o  out  32  always 0; m_sel_o out 4, always 4'hF; m_wen_o out 1, always 0.
REQ-010 m_ren_o  out  1  read strobe, one-cycle pulse.
REQ-011 m_rdata_i  in  32  read data, valid when m_ack_i=1.
REQ-012 m_ack_i  in  1  acknowledge; m_err_i in 1, bus error qualifier.
REQ-013 rec_valid_o  out  1; rec_ready_i in 1: record stream handshake.
REQ-014 rec_type_o out 1 (0 alpha, 1 gamma); rec_amp_o out 14 signed; rec_t0_o, rec_t1_o, rec_t2_o out 32 each.
REQ-015 rec_cnt_o  out  32  records delivered; err_cnt_o out 16, bus errors and timeouts; busy_o out 1, FSM not in IDLE.

Function
REQ-016 FSM states: IDLE, STAT, T0, T1, T2, OUT, GAP.
REQ-017 Each bus read: assert m_ren_o for exactly one cycle with m_addr_o set. Hold m_addr_o stable until m_ack_i. Capture m_rdata_i in the ack cycle.
REQ-018 IDLE: when enable_i=1, go to STAT and read BASE_ADDR+0x20.
REQ-019 STAT ack, bit31=0: go to GAP with POLL_GAP.
REQ-020 STAT ack, bit31=1: latch type=bit30 and amp=bits[29:16]; read 0x24 (T0), then 0x28 (T1), then 0x2C (T2), strictly in that order.
REQ-021 The 0x2C read is the pop. It is issued at most once per status-valid record and never without a preceding valid status.
REQ-022 T2 ack: go to OUT and assert rec_valid_o with all record fields registered. Fields hold stable while rec_valid_o=1 and rec_ready_i=0.
REQ-023 OUT: on rec_valid_o & rec_ready_i, deassert rec_valid_o, increment rec_cnt_o (wraps at 2^32), and go to GAP with POP_GAP.
REQ-024 GAP: count down the loaded gap. At zero, go to STAT if enable_i=1, else to IDLE.
REQ-025 enable_i=0 is honoured only in IDLE/GAP. A record already in progress completes through OUT, so a popped record is never lost.
REQ-026 Timeout: a down-counter loads TIMEOUT at each strobe. If it expires before ack: err_cnt_o +1 (saturates at 16'hFFFF), drop the partial record, go to GAP with POLL_GAP.
REQ-027 m_err_i=1 with ack: same action as a timeout. If this happens on the 0x2C read, the record is still dropped.
REQ-028 Ack arriving while no read is outstanding is ignored.
REQ-029 Read-to-read turnaround is 1 idle cycle minimum. Best case is a valid record presented 8 cycles after leaving IDLE with ack latency 1.

Reset
REQ-030 On rstn_i low, asynchronously: FSM=IDLE; m_ren_o=0; m_addr_o=BASE_ADDR+0x20; rec_valid_o=0; all rec_* fields=0; rec_cnt_o=0; err_cnt_o=0; busy_o=0; gap and timeout counters=0.
REQ-031 Reset mid-transaction abandons it with no further strobes. A record popped but undelivered at reset is lost by definition.

Structure
REQ-032 A shared package lfs_pkg holds the register offsets (0x20, 0x24, 0x28, 0x2C), the status bit positions (valid 31, type 30, amp 29:16), and the FSM state enum.
REQ-033 The block is a single module; no sub-module.

Verification
REQ-034 Bench responder model mimics the counter bus timing (ack one cycle after strobe) and holds a record queue.
REQ-035 Queue holds one record {gamma, amp=-100, t0=5, t1=12, t2=3}; rec_ready_i=1 -> one rec_valid_o pulse with exactly those values, exactly one 0x2C read, rec_cnt_o=1.
REQ-036 Queue empty, enable_i=1 for 100 cycles -> only 0x20 reads, spaced POLL_GAP+2 cycles apart; rec_valid_o never asserted.
REQ-037 Three records queued, rec_ready_i held 0 for 50 cycles -> record 1 held stable, no further bus reads; release ready -> all 3 delivered in order, rec_cnt_o=3.
REQ-038 Responder withholds ack on the 0x28 read -> after TIMEOUT cycles err_cnt_o=1, no 0x2C read issued, polling resumes after the gap.
REQ-039 enable_i dropped the cycle after the 0x24 ack -> 0x28 and 0x2C still read, record delivered, then IDLE with no further strobes.
REQ-040 rstn_i asserted during the T1 wait -> all outputs at reset values immediately; after release with enable_i=1, the first strobe is a 0x20 read.

Source files
------------

// File: rtl/lfs_pkg.sv
// lfs_pkg: register offsets, status field positions and FSM states for the LFS event reader
package lfs_pkg;
  localparam logic [31:0] OFF_STAT = 32'h20;
  localparam logic [31:0] OFF_T0 = 32'h24;
  localparam logic [31:0] OFF_T1 = 32'h28;
  localparam logic [31:0] OFF_T2 = 32'h2C;
  localparam int ST_VALID = 31;
  localparam int ST_TYPE = 30;
  localparam int AMP_HI = 29;
  localparam int AMP_LO = 16;
  typedef enum logic [2:0] {IDLE, STAT, T0, T1, T2, OUT, GAP} state_e;
endpackage

// File: rtl/lfs_evt_reader.sv
// lfs_evt_reader: polls the LFS counter FIFO over a read bus and streams out event records
module lfs_evt_reader
  import lfs_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int POLL_GAP = 16,
  parameter int POP_GAP = 8,
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic enable_i,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0] m_sel_o,
  output logic m_wen_o,
  output logic m_ren_o,
  input  logic [31:0] m_rdata_i,
  input  logic m_ack_i,
  input  logic m_err_i,
  output logic rec_valid_o,
  input  logic rec_ready_i,
  output logic rec_type_o,
  output logic signed [13:0] rec_amp_o,
  output logic [31:0] rec_t0_o,
  output logic [31:0] rec_t1_o,
  output logic [31:0] rec_t2_o,
  output logic [31:0] rec_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic busy_o
);
  localparam logic [15:0] POLL_LD = 16'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);
  localparam logic [15:0] POP_LD = 16'(POP_GAP > 0 ? POP_GAP - 1 : 0);
  localparam logic [31:0] TMO_LD = 32'(TIMEOUT);
  state_e state_q, state_d;
  logic ren_q, ren_d, type_q, type_d, rd, rd_st, ok, bad;
  logic [31:0] addr_q, addr_d, t0_q, t0_d, t1_q, t1_d, t2_q, t2_d, cnt_q, cnt_d, tmo_q, tmo_d, off;
  logic signed [13:0] amp_q, amp_d;
  logic [15:0] gap_q, gap_d, err_q, err_d;
  assign rd_st = state_q inside {STAT, T0, T1, T2};
  assign ok = rd_st && m_ack_i && !m_err_i;
  assign bad = rd_st && (m_ack_i ? m_err_i : tmo_q == '0);
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    gap_d = gap_q;
    tmo_d = tmo_q;
    type_d = type_q;
    amp_d = amp_q;
    t0_d = t0_q;
    t1_d = t1_q;
    t2_d = t2_q;
    cnt_d = cnt_q;
    err_d = err_q;
    rd = 1'b0;
    off = OFF_STAT;
    case (state_q)
      IDLE: if (enable_i) begin
        state_d = STAT;
        rd = 1'b1;
      end
      STAT: if (ok) begin
        if (m_rdata_i[ST_VALID]) begin
          state_d = T0;
          rd = 1'b1;
          off = OFF_T0;
          type_d = m_rdata_i[ST_TYPE];
          amp_d = $signed(m_rdata_i[AMP_HI:AMP_LO]);
        end else begin
          state_d = GAP;
          gap_d = POLL_LD;
        end
      end
      T0: if (ok) begin
        state_d = T1;
        rd = 1'b1;
        off = OFF_T1;
        t0_d = m_rdata_i;
      end
      T1: if (ok) begin
        state_d = T2;
        rd = 1'b1;
        off = OFF_T2;
        t1_d = m_rdata_i;
      end
      T2: if (ok) begin
        state_d = OUT;
        t2_d = m_rdata_i;
      end
      OUT: if (rec_ready_i) begin
        state_d = GAP;
        gap_d = POP_LD;
        cnt_d = cnt_q + 32'd1;
      end
      GAP: if (gap_q != '0) gap_d = gap_q - 16'd1;
        else if (enable_i) begin
          state_d = STAT;
          rd = 1'b1;
        end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bad) begin
      state_d = GAP;
      gap_d = POLL_LD;
      err_d = err_q + {15'd0, err_q != 16'hFFFF};
    end
    if (rd) begin
      addr_d = BASE_ADDR + off;
      tmo_d = TMO_LD;
    end else if (rd_st && tmo_q != '0) tmo_d = tmo_q - 32'd1;
    ren_d = rd;
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      state_q <= IDLE;
      ren_q <= 1'b0;
      addr_q <= BASE_ADDR + OFF_STAT;
      gap_q <= '0;
      tmo_q <= '0;
      type_q <= 1'b0;
      amp_q <= '0;
      t0_q <= '0;
      t1_q <= '0;
      t2_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      ren_q <= ren_d;
      addr_q <= addr_d;
      gap_q <= gap_d;
      tmo_q <= tmo_d;
      type_q <= type_d;
      amp_q <= amp_d;
      t0_q <= t0_d;
      t1_q <= t1_d;
      t2_q <= t2_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign m_addr_o = addr_q;
  assign m_ren_o = ren_q;
  assign m_wdata_o = '0;
  assign m_sel_o = 4'hF;
  assign m_wen_o = 1'b0;
  assign rec_valid_o = state_q == OUT;
  assign rec_type_o = type_q;
  assign rec_amp_o = amp_q;
  assign rec_t0_o = t0_q;
  assign rec_t1_o = t1_q;
  assign rec_t2_o = t2_q;
  assign rec_cnt_o = cnt_q;
  assign err_cnt_o = err_q;
  assign busy_o = state_q != IDLE;
endmodule
